boundary_reflect: RTL and testbench
===================================

Name: boundary_reflect

Overview:
- Downstream neighbour of the kinematic update stage.
- Captures each updated particle state (xnew, ynew, vxnew, vynew) on the update stage's one-cycle out_rdy pulse and buffers it in a small FIFO, because upstream has no backpressure.
- Reflects position and velocity off the arena walls and presents the corrected state to the next consumer (state store / feedback to update stage) with a valid/ack handshake.

Parameters:
- FIFO_DEPTH, 4, input buffer entries (power of two, ≥2)
- XMIN, -1000, left wall (signed 16-bit)
- XMAX, 1000, right wall (signed 16-bit)
- YMIN, -1000, bottom wall
- YMAX, 1000, top wall
- DAMP_SHIFT, 2, damping shift; used only with the optional feature

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_vld  in  1  one-cycle capture strobe, driven by update stage out_rdy
- xnew  in  16  signed position x
- ynew  in  16  signed position y
- vxnew  in  16  signed velocity x
- vynew  in  16  signed velocity y
- out_vld  out  1  corrected state valid
- out_ack  in  1  consumer accepts state
- x_out  out  16  corrected x
- y_out  out  16  corrected y
- vx_out  out  16  corrected vx
- vy_out  out  16  corrected vy
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries
- overflow  out  1  sticky: a push was dropped
- bounce_count  out  16  total wall reflections, wraps at 65535→0

Behaviour:
- Reset (async assert, sync release):
  - out_vld, x/y/vx/vy_out, overflow, bounce_count = 0; fifo_full = 0.
  - FIFO emptied; FSM = IDLE.
  - Reset mid-operation discards in-flight and buffered states.
- Arithmetic: all values are 16-bit two's complement.
- Push:
  - in_vld=1 at an edge writes {xnew, ynew, vxnew, vynew} into the FIFO.
  - Full and no pop that edge → entry dropped, overflow set until reset.
  - Full with a pop the same edge → push accepted.
- FSM states and transitions:
  - IDLE: FIFO non-empty → pop into working registers, go to CHK_X.
  - CHK_X: apply reflect to (x, vx) against XMIN/XMAX, go to CHK_Y.
  - CHK_Y: apply reflect to (y, vy) against YMIN/YMAX, load outputs, out_vld←1, go to HOLD.
  - HOLD: outputs stable while out_vld=1. out_ack=1 at an edge → out_vld←0 and go to IDLE. Back-to-back entries therefore cost 4 cycles each minimum.
- Latency: empty FIFO and FSM in IDLE → out_vld rises 3 edges after the edge that samples in_vld.
- Reflect rule (per axis, 18-bit intermediate):
  - p > MAX: p' = 2·MAX − p, v' = −v.
  - p < MIN: p' = 2·MIN − p, v' = −v.
  - Otherwise pass p and v through unchanged.
  - p' clamped to [MIN, MAX] (handles overshoot of more than one arena width).
  - −(−32768) saturates to 32767.
  - p = MIN or p = MAX exactly is not a bounce.
- bounce_count increments by 1 per reflecting axis; both axes in one entry → +2 total (one in CHK_X, one in CHK_Y).
- out_ack while out_vld=0 is ignored.

Optional Feature:
- Macro: BOUNCE_DAMP_EN.
- Defined: on reflection, v' = −(v − (v >>> DAMP_SHIFT)) (arithmetic shift), then saturation applies.
- Undefined: v' = −v exactly; DAMP_SHIFT unused.
- Position rule is identical either way.

Decomposition:
- Shared package/header kin_defs:
  - data width 16, intermediate width 18
  - state encoding IDLE/CHK_X/CHK_Y/HOLD
  - packed FIFO entry record (64 bits)
- Sub-module reflect_axis: combinational (p, v, MIN, MAX) → (p', v', bounced). Instantiated twice, or once and time-shared by the FSM.
- FIFO inline (pointer + count).

Test Plan:
- x=1010, vx=20, y=0, vy=5 → x_out=990, vx_out=−20, y_out=0, vy_out=5, bounce_count=1; out_vld 3 edges after in_vld.
- x=−1005, vx=−3, y=1002, vy=7 → x_out=−995, vx_out=3, y_out=998, vy_out=−7, bounce_count +2.
- x=3100, vx=−32768 → x_out clamped to −1000, vx_out=32767. With BOUNCE_DAMP_EN: vx=20 on bounce → vx_out=−15.
- Five in_vld pulses on consecutive cycles with out_ack held 0 → fifo_full=1 after fourth, fifth dropped, overflow=1. Then hold out_ack=1 → exactly four outputs emitted, in order.
- FIFO full while HOLD is acked and the pop happens on the same edge as in_vld → push accepted, overflow stays 0.
- Assert reset while in CHK_Y with 2 entries buffered → out_vld=0 and outputs 0 immediately (async); no outputs after release until a new in_vld.

Source files
------------

// File: rtl/kin_defs.sv
// rtl/kin_defs.sv - shared widths, FSM state encoding and FIFO entry record
package kin_defs;
  localparam int DATA_W = 16;
  localparam int INT_W  = 18;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHK_X = 2'd1,
    CHK_Y = 2'd2,
    HOLD  = 2'd3
  } state_t;

  typedef struct packed {
    logic signed [DATA_W-1:0] x;
    logic signed [DATA_W-1:0] y;
    logic signed [DATA_W-1:0] vx;
    logic signed [DATA_W-1:0] vy;
  } entry_t;
endpackage

// File: rtl/reflect_axis.sv
// rtl/reflect_axis.sv - combinational wall reflection of one (p, v) axis pair
// BOUNCE_DAMP_EN: reflected speed is reduced by v >>> DAMP_SHIFT before negation.
module reflect_axis
  import kin_defs::*;
#(
  parameter int DAMP_SHIFT = 2
) (
  input  logic signed [DATA_W-1:0] p,
  input  logic signed [DATA_W-1:0] v,
  input  logic signed [DATA_W-1:0] p_min,
  input  logic signed [DATA_W-1:0] p_max,
  output logic signed [DATA_W-1:0] p_out,
  output logic signed [DATA_W-1:0] v_out,
  output logic                     bounced
);

  localparam logic signed [INT_W-1:0] SAT_MAX = 18'sd32767;
  localparam logic signed [INT_W-1:0] SAT_MIN = -18'sd32768;

  logic signed [DATA_W-1:0] v_mag;
  logic signed [INT_W-1:0]  p_w, min_w, max_w, p_r, v_neg;

`ifdef BOUNCE_DAMP_EN
  assign v_mag = v - (v >>> DAMP_SHIFT);
`else
  logic signed [DATA_W-1:0] unused_damp;
  assign unused_damp = v >>> DAMP_SHIFT;
  assign v_mag = v;
`endif

  assign p_w   = {{(INT_W-DATA_W){p[DATA_W-1]}}, p};
  assign min_w = {{(INT_W-DATA_W){p_min[DATA_W-1]}}, p_min};
  assign max_w = {{(INT_W-DATA_W){p_max[DATA_W-1]}}, p_max};
  assign v_neg = -{{(INT_W-DATA_W){v_mag[DATA_W-1]}}, v_mag};

  always_comb begin
    bounced = 1'b0;
    p_r     = p_w;
    v_out   = v;
    if (p_w > max_w) begin
      p_r     = (max_w <<< 1) - p_w;
      bounced = 1'b1;
    end else if (p_w < min_w) begin
      p_r     = (min_w <<< 1) - p_w;
      bounced = 1'b1;
    end
    // Overshoot by more than one arena width still lands on a wall.
    if (p_r > max_w)
      p_r = max_w;
    else if (p_r < min_w)
      p_r = min_w;
    p_out = p_r[DATA_W-1:0];
    if (bounced) begin
      if (v_neg > SAT_MAX)
        v_out = 16'sh7FFF;
      else if (v_neg < SAT_MIN)
        v_out = 16'sh8000;
      else
        v_out = v_neg[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/boundary_reflect.sv
// rtl/boundary_reflect.sv - FIFO-buffered arena wall reflection with valid/ack output
// BOUNCE_DAMP_EN (consumed by reflect_axis) selects damped reflected velocity.
module boundary_reflect
  import kin_defs::*;
#(
  parameter int                       FIFO_DEPTH = 4,
  parameter logic signed [DATA_W-1:0] XMIN       = -16'sd1000,
  parameter logic signed [DATA_W-1:0] XMAX       = 16'sd1000,
  parameter logic signed [DATA_W-1:0] YMIN       = -16'sd1000,
  parameter logic signed [DATA_W-1:0] YMAX       = 16'sd1000,
  parameter int                       DAMP_SHIFT = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_vld,
  input  logic signed [DATA_W-1:0] xnew,
  input  logic signed [DATA_W-1:0] ynew,
  input  logic signed [DATA_W-1:0] vxnew,
  input  logic signed [DATA_W-1:0] vynew,
  output logic                     out_vld,
  input  logic                     out_ack,
  output logic signed [DATA_W-1:0] x_out,
  output logic signed [DATA_W-1:0] y_out,
  output logic signed [DATA_W-1:0] vx_out,
  output logic signed [DATA_W-1:0] vy_out,
  output logic                     fifo_full,
  output logic                     overflow,
  output logic [DATA_W-1:0]        bounce_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  state_t state, state_nxt;

  entry_t           mem [FIFO_DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;

  logic signed [DATA_W-1:0] wx, wy, wvx, wvy;
  logic signed [DATA_W-1:0] ax_p, ax_v, ax_min, ax_max, ax_p_out, ax_v_out;
  logic                     ax_bounced, sel_y;

  // The FSM only pops in IDLE, so a full FIFO accepts a push only on that edge.
  assign pop       = (state == IDLE) && (count != '0);
  assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
  assign push      = in_vld && (!fifo_full || pop);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= {xnew, ynew, vxnew, vynew};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (in_vld && !push)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = CHK_X;
      CHK_X:   state_nxt = CHK_Y;
      CHK_Y:   state_nxt = HOLD;
      HOLD:    if (out_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One reflector, shared between the X and Y check states.
  assign sel_y  = (state == CHK_Y);
  assign ax_p   = sel_y ? wy   : wx;
  assign ax_v   = sel_y ? wvy  : wvx;
  assign ax_min = sel_y ? YMIN : XMIN;
  assign ax_max = sel_y ? YMAX : XMAX;

  reflect_axis #(
    .DAMP_SHIFT(DAMP_SHIFT)
  ) u_reflect (
    .p      (ax_p),
    .v      (ax_v),
    .p_min  (ax_min),
    .p_max  (ax_max),
    .p_out  (ax_p_out),
    .v_out  (ax_v_out),
    .bounced(ax_bounced)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wx           <= '0;
      wy           <= '0;
      wvx          <= '0;
      wvy          <= '0;
      x_out        <= '0;
      y_out        <= '0;
      vx_out       <= '0;
      vy_out       <= '0;
      out_vld      <= 1'b0;
      bounce_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            wx  <= head.x;
            wy  <= head.y;
            wvx <= head.vx;
            wvy <= head.vy;
          end
        end
        CHK_X: begin
          wx           <= ax_p_out;
          wvx          <= ax_v_out;
          bounce_count <= bounce_count + DATA_W'(ax_bounced);
        end
        CHK_Y: begin
          x_out        <= wx;
          vx_out       <= wvx;
          y_out        <= ax_p_out;
          vy_out       <= ax_v_out;
          out_vld      <= 1'b1;
          bounce_count <= bounce_count + DATA_W'(ax_bounced);
        end
        HOLD: begin
          if (out_ack)
            out_vld <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_boundary_reflect.sv
// tb/tb_boundary_reflect.sv - directed self-checking bench for boundary_reflect
// BOUNCE_DAMP_EN switches the expected reflected velocities.
module tb_boundary_reflect;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               in_vld = 1'b0;
  logic               out_ack = 1'b0;
  logic signed [15:0] xnew = '0, ynew = '0, vxnew = '0, vynew = '0;
  logic               out_vld, fifo_full, overflow;
  logic signed [15:0] x_out, y_out, vx_out, vy_out;
  logic [15:0]        bounce_count;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef BOUNCE_DAMP_EN
  localparam logic signed [15:0] E1_VX = -16'sd15;
  localparam logic signed [15:0] E2_VX = 16'sd2;
  localparam logic signed [15:0] E2_VY = -16'sd6;
  localparam logic signed [15:0] E3_VX = 16'sd24576;
`else
  localparam logic signed [15:0] E1_VX = -16'sd20;
  localparam logic signed [15:0] E2_VX = 16'sd3;
  localparam logic signed [15:0] E2_VY = -16'sd7;
  localparam logic signed [15:0] E3_VX = 16'sd32767;
`endif

  boundary_reflect dut (
    .clock       (clock),
    .reset       (reset),
    .in_vld      (in_vld),
    .xnew        (xnew),
    .ynew        (ynew),
    .vxnew       (vxnew),
    .vynew       (vynew),
    .out_vld     (out_vld),
    .out_ack     (out_ack),
    .x_out       (x_out),
    .y_out       (y_out),
    .vx_out      (vx_out),
    .vy_out      (vy_out),
    .fifo_full   (fifo_full),
    .overflow    (overflow),
    .bounce_count(bounce_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic signed [15:0] obs, input logic signed [15:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Called at a negedge; the pulse is sampled by the following posedge.
  task automatic push_one(input logic signed [15:0] x, input logic signed [15:0] y,
                          input logic signed [15:0] vx, input logic signed [15:0] vy);
    xnew = x; ynew = y; vxnew = vx; vynew = vy;
    in_vld = 1'b1;
    @(negedge clock);
  endtask

  task automatic wait_vld(input string tag);
    int n = 0;
    while (!out_vld && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_vld"}, 16'(out_vld), 16'sd1);
  endtask

  task automatic ack_one();
    out_ack = 1'b1;
    @(negedge clock);
    out_ack = 1'b0;
  endtask

  initial begin
    logic signed [15:0] got[$];
    int hi;

    #2;
    chk("rst_vld", 16'(out_vld), 0);
    chk("rst_x", x_out, 0);
    chk("rst_vy", vy_out, 0);
    chk("rst_full", 16'(fifo_full), 0);
    chk("rst_ovf", 16'(overflow), 0);
    chk("rst_bounce", bounce_count, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Right wall on X only, with exact 3-edge latency.
    push_one(16'sd1010, 16'sd0, 16'sd20, 16'sd5);
    in_vld = 1'b0;
    chk("lat_e0", 16'(out_vld), 0);
    @(negedge clock); chk("lat_e1", 16'(out_vld), 0);
    @(negedge clock); chk("lat_e2", 16'(out_vld), 0);
    @(negedge clock); chk("lat_e3", 16'(out_vld), 1);
    chk("v1_x", x_out, 16'sd990);
    chk("v1_vx", vx_out, E1_VX);
    chk("v1_y", y_out, 16'sd0);
    chk("v1_vy", vy_out, 16'sd5);
    chk("v1_bounce", bounce_count, 1);
    @(negedge clock);
    chk("v1_hold_vld", 16'(out_vld), 1);
    chk("v1_hold_x", x_out, 16'sd990);
    ack_one();
    chk("v1_ack_drop", 16'(out_vld), 0);
    out_ack = 1'b1;
    @(negedge clock);
    @(negedge clock);
    out_ack = 1'b0;
    chk("idle_ack_vld", 16'(out_vld), 0);
    chk("idle_ack_x", x_out, 16'sd990);

    // Left wall on X and top wall on Y.
    push_one(-16'sd1005, 16'sd1002, -16'sd3, 16'sd7);
    in_vld = 1'b0;
    wait_vld("v2");
    chk("v2_x", x_out, -16'sd995);
    chk("v2_vx", vx_out, E2_VX);
    chk("v2_y", y_out, 16'sd998);
    chk("v2_vy", vy_out, E2_VY);
    chk("v2_bounce", bounce_count, 3);
    ack_one();

    // Multi-width overshoot clamps; most negative velocity saturates.
    push_one(16'sd3100, 16'sd0, 16'sh8000, 16'sd0);
    in_vld = 1'b0;
    wait_vld("v3");
    chk("v3_x", x_out, -16'sd1000);
    chk("v3_vx", vx_out, E3_VX);
    chk("v3_y", y_out, 16'sd0);
    chk("v3_bounce", bounce_count, 4);
    ack_one();

    // Sitting exactly on the walls is not a bounce.
    push_one(16'sd1000, -16'sd1000, 16'sd20, -16'sd4);
    in_vld = 1'b0;
    wait_vld("v4");
    chk("v4_x", x_out, 16'sd1000);
    chk("v4_vx", vx_out, 16'sd20);
    chk("v4_y", y_out, -16'sd1000);
    chk("v4_vy", vy_out, -16'sd4);
    chk("v4_bounce", bounce_count, 4);
    ack_one();

    // Overflow: FSM parked in HOLD, five back-to-back pushes.
    push_one(16'sd5, 16'sd0, 16'sd1, 16'sd1);
    in_vld = 1'b0;
    wait_vld("prime");
    push_one(16'sd10, 16'sd0, 16'sd1, 16'sd1);
    push_one(16'sd20, 16'sd0, 16'sd1, 16'sd1);
    push_one(16'sd30, 16'sd0, 16'sd1, 16'sd1);
    push_one(16'sd40, 16'sd0, 16'sd1, 16'sd1);
    chk("ovf_full4", 16'(fifo_full), 1);
    chk("ovf_pre", 16'(overflow), 0);
    push_one(16'sd50, 16'sd0, 16'sd1, 16'sd1);
    in_vld = 1'b0;
    chk("ovf_set", 16'(overflow), 1);
    chk("ovf_full5", 16'(fifo_full), 1);
    chk("ovf_prime_x", x_out, 16'sd5);
    ack_one();
    out_ack = 1'b1;
    got.delete();
    for (int i = 0; i < 40; i++) begin
      if (out_vld) got.push_back(x_out);
      @(negedge clock);
    end
    out_ack = 1'b0;
    chk("ovf_count", 16'(got.size()), 4);
    for (int i = 0; i < got.size() && i < 4; i++)
      chk($sformatf("ovf_order%0d", i), got[i], 16'(10 * (i + 1)));
    chk("ovf_drained", 16'(fifo_full), 0);
    chk("ovf_sticky", 16'(overflow), 1);

    // Push onto a full FIFO on the same edge IDLE pops.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst2_ovf", 16'(overflow), 0);
    chk("rst2_bounce", bounce_count, 0);
    push_one(16'sd7, 16'sd0, 16'sd0, 16'sd0);
    in_vld = 1'b0;
    wait_vld("prime2");
    push_one(16'sd100, 16'sd0, 16'sd0, 16'sd0);
    push_one(16'sd200, 16'sd0, 16'sd0, 16'sd0);
    push_one(16'sd300, 16'sd0, 16'sd0, 16'sd0);
    push_one(16'sd400, 16'sd0, 16'sd0, 16'sd0);
    in_vld = 1'b0;
    chk("same_full_pre", 16'(fifo_full), 1);
    ack_one();
    push_one(16'sd500, 16'sd0, 16'sd0, 16'sd0);
    in_vld = 1'b0;
    chk("same_ovf", 16'(overflow), 0);
    chk("same_full_post", 16'(fifo_full), 1);
    out_ack = 1'b1;
    got.delete();
    for (int i = 0; i < 40; i++) begin
      if (out_vld) got.push_back(x_out);
      @(negedge clock);
    end
    out_ack = 1'b0;
    chk("same_count", 16'(got.size()), 5);
    for (int i = 0; i < got.size() && i < 5; i++)
      chk($sformatf("same_order%0d", i), got[i], 16'(100 * (i + 1)));

    // Reset while in CHK_Y with two entries buffered.
    push_one(16'sd11, 16'sd0, 16'sd0, 16'sd0);
    push_one(16'sd22, 16'sd0, 16'sd0, 16'sd0);
    push_one(16'sd33, 16'sd0, 16'sd0, 16'sd0);
    in_vld = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_vld", 16'(out_vld), 0);
    chk("mid_rst_x", x_out, 0);
    chk("mid_rst_full", 16'(fifo_full), 0);
    @(negedge clock);
    reset = 1'b0;
    out_ack = 1'b1;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_vld) hi++;
      @(negedge clock);
    end
    out_ack = 1'b0;
    chk("mid_rst_quiet", 16'(hi), 0);
    push_one(16'sd44, 16'sd3, 16'sd0, 16'sd0);
    in_vld = 1'b0;
    wait_vld("after_rst");
    chk("after_rst_x", x_out, 16'sd44);
    chk("after_rst_y", y_out, 16'sd3);
    ack_one();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
